// File: rtl/cache_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Bundles every handshake and bus signal around the cache/memory arbiter:
//   I-cache side : i_req, i_addr              -> arbiter
//                  i_ack, i_rdata, i_err      <- arbiter
//   D-cache side : d_req, d_we, d_addr,
//                  d_boff, d_wdata            -> arbiter
//                  d_ack, d_rdata, d_err      <- arbiter
//   Memory side  : mem_req, mem_we, mem_addr,
//                  mem_boff, mem_wdata        <- arbiter
//                  mem_rdata, mem_ack         -> arbiter
//   Status       : arb_busy, owner_d          <- arbiter
//
// Modports:
//   master : the arbiter itself (it masters the shared memory port)
//   slave  : the surrounding system (both caches plus main memory)
// ----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32
);

    // I-cache requester
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_rdata;
    logic              i_err;

    // D-cache requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        d_boff;
    logic [WORD_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;
    logic              d_err;

    // Shared main-memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_boff;
    logic [WORD_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    // Status
    logic              arb_busy;
    logic              owner_d;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_boff, d_wdata,
        input  mem_rdata, mem_ack,
        output i_ack, i_rdata, i_err,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_boff, mem_wdata,
        output arb_busy, owner_d
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_boff, d_wdata,
        output mem_rdata, mem_ack,
        input  i_ack, i_rdata, i_err,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_boff, mem_wdata,
        input  arb_busy, owner_d
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one main-memory port between the I-cache line-refill requester and
// the D-cache requester (line refill or write-through word). Requests are
// arbitrated round-robin, exactly one memory transaction is in flight at a
// time, and the winner receives a single-cycle ack carrying either the read
// line, zero (writes) or a timeout error.
//
// Ports:
//   clk      : clock
//   reset_n  : asynchronous, active-low reset
//   bus      : cache_mem_arbiter_if.master -- I/D request/response channels,
//              memory request/response channel, arb_busy and owner_d status
//
// Parameters:
//   ADDR_W         : line address width
//   LINE_W         : refill line width
//   WORD_W         : write-through word width
//   TIMEOUT_CYCLES : max BUSY cycles waiting for mem_ack, 0 disables timeout
//
// Every output is driven straight from a flop.
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int LINE_W         = 128,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    cache_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter must be able to hold TIMEOUT_CYCLES; a disabled timeout still
    // needs a legal one-bit vector.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t            state_q,     state_d;
    logic              owner_d_q,   owner_d_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              arb_busy_q,  arb_busy_d;

    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [1:0]        mem_boff_q,  mem_boff_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              i_ack_q,     i_ack_d;
    logic [LINE_W-1:0] i_rdata_q,   i_rdata_d;
    logic              i_err_q,     i_err_d;
    logic              d_ack_q,     d_ack_d;
    logic [LINE_W-1:0] d_rdata_q,   d_rdata_d;
    logic              d_err_q,     d_err_d;

    logic              grant_d;
    logic              timeout_hit;
    logic [LINE_W-1:0] resp_line;

    // Next-state and next-output logic.
    // The ack/err/rdata outputs default to zero so that they form a
    // one-cycle pulse in RESP; everything on the memory side holds its
    // value unless a grant or completion changes it.
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_boff_d  = mem_boff_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = '0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_rdata_d   = '0;
        d_err_d     = 1'b0;
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        resp_line   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the D-cache wins unless it had the last grant.
                    grant_d   = bus.d_req && (!bus.i_req || !owner_d_q);
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    owner_d_d = grant_d;
                    cnt_d     = '0;
                    if (grant_d) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_boff_d  = bus.d_boff;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_boff_d  = 2'd0;
                        mem_wdata_d = '0;
                    end
                end
            end

            BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
                // A mem_ack arriving in the last allowed cycle still counts
                // as a normal completion, so it is tested first.
                if (bus.mem_ack || timeout_hit) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (bus.mem_ack && !mem_we_q) begin
                        resp_line = bus.mem_rdata;
                    end
                    if (owner_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_line;
                        d_err_d   = !bus.mem_ack;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_line;
                        i_err_d   = !bus.mem_ack;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset aborts any transaction in flight
    // and drops mem_req without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            cnt_q       <= '0;
            arb_busy_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_boff_q  <= 2'd0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            cnt_q       <= cnt_d;
            arb_busy_q  <= arb_busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_boff_q  <= mem_boff_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_boff  = mem_boff_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.arb_busy  = arb_busy_q;
    assign bus.owner_d   = owner_d_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. Directed requests are queued
// per requester; the expected memory requests and expected acks are pushed
// into scoreboard queues by hand, and a monitor pops and compares them as
// the DUT presents mem_req rises and i_ack/d_ack pulses.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

    localparam int ADDR_W         = 8;
    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int TIMEOUT_CYCLES = 4;
    localparam logic [LINE_W-1:0] BASE_LINE = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        boff;
        logic [WORD_W-1:0] wdata;
    } req_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        boff;
        logic [WORD_W-1:0] wdata;
        logic              owner;
        int                hi;
    } exp_mem_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] rdata;
        logic              err;
    } exp_ack_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    req_t     i_q[$];
    req_t     d_q[$];
    exp_mem_t exp_mem_q[$];
    exp_ack_t exp_ack_q[$];

    int               mem_latency = 2;
    bit               stray_ack   = 1'b0;
    logic [ADDR_W-1:0] d_addr_xor = '0;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) bus ();

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory returns a line whose upper half is tagged with the address.
    function automatic logic [LINE_W-1:0] line_for(input logic [ADDR_W-1:0] a);
        return BASE_LINE ^ (LINE_W'(a) << 64);
    endfunction

    function automatic req_t mk_req(input logic we, input logic [ADDR_W-1:0] a,
                                    input logic [1:0] b, input logic [WORD_W-1:0] w);
        req_t r;
        r.we = we; r.addr = a; r.boff = b; r.wdata = w;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [LINE_W-1:0] actual,
                                input logic [LINE_W-1:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic record_fail(input string name, input string detail);
        total_cnt++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    task automatic apply_stimulus(input bit is_d, input req_t r);
        if (is_d) d_q.push_back(r);
        else      i_q.push_back(r);
    endtask

    task automatic expect_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [1:0] b,
                              input logic [WORD_W-1:0] w, input logic owner, input int hi);
        exp_mem_t e;
        e.we = we; e.addr = a; e.boff = b; e.wdata = w; e.owner = owner; e.hi = hi;
        exp_mem_q.push_back(e);
    endtask

    task automatic expect_ack(input logic is_d, input logic [LINE_W-1:0] rdata, input logic err);
        exp_ack_t e;
        e.is_d = is_d; e.rdata = rdata; e.err = err;
        exp_ack_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string name);
        int n = 0;
        while (!bus.mem_req && n < 20) begin
            tick();
            n++;
        end
        check_output(name, LINE_W'(bus.mem_req), 1);
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
            done = (i_q.size() == 0) && (d_q.size() == 0) && (exp_mem_q.size() == 0) &&
                   (exp_ack_q.size() == 0) && !bus.arb_busy && !bus.mem_req;
        end
        check_output(name, LINE_W'(done), 1);
        check_output({name, "_resp_cleared"},
                     bus.i_rdata | bus.d_rdata | LINE_W'({bus.i_err, bus.d_err, bus.i_ack, bus.d_ack}), 0);
    endtask

    // I-cache requester: holds i_req while it has work, retires on i_ack.
    initial begin
        bus.i_req  = 1'b0;
        bus.i_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.i_ack && i_q.size() > 0) void'(i_q.pop_front());
            if (i_q.size() > 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = i_q[0].addr;
            end else begin
                bus.i_req  = 1'b0;
            end
        end
    end

    // D-cache requester: same behaviour; d_addr_xor lets the bench disturb
    // the address while a transaction is in flight.
    initial begin
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_boff  = 2'd0;
        bus.d_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.d_ack && d_q.size() > 0) void'(d_q.pop_front());
            if (d_q.size() > 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = d_q[0].we;
                bus.d_addr  = d_q[0].addr ^ d_addr_xor;
                bus.d_boff  = d_q[0].boff;
                bus.d_wdata = d_q[0].wdata;
            end else begin
                bus.d_req   = 1'b0;
            end
        end
    end

    // Memory model: acks after mem_req has been high mem_latency cycles;
    // mem_latency = 0 never acks.
    initial begin
        int mem_wait = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (stray_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = BASE_LINE;
                stray_ack     = 1'b0;
            end else if (!reset_n || !bus.mem_req) begin
                mem_wait = 0;
            end else begin
                mem_wait++;
                if (mem_latency > 0 && mem_wait == mem_latency) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = line_for(bus.mem_addr);
                end
            end
        end
    end

    // Monitor: checks memory requests and acks against the scoreboards.
    initial begin
        exp_mem_t cur;
        exp_ack_t ea;
        bit       active    = 1'b0;
        bit       prev_req  = 1'b0;
        bit       prev_mack = 1'b0;
        bit       busy_next = 1'b0;
        int       hi        = 0;
        cur.hi = -1;
        forever begin
            tick();
            if (!reset_n) begin
                active = 1'b0; prev_req = 1'b0; prev_mack = 1'b0; busy_next = 1'b0;
                continue;
            end
            if (bus.mem_req && !prev_req) begin
                if (exp_mem_q.size() == 0) begin
                    record_fail("unexpected_mem_req", $sformatf("got addr 0x%0h, expected none", bus.mem_addr));
                end else begin
                    cur = exp_mem_q.pop_front();
                    active = 1'b1;
                    hi = 1;
                    check_output("mem_we",    LINE_W'(bus.mem_we),    LINE_W'(cur.we));
                    check_output("mem_addr",  LINE_W'(bus.mem_addr),  LINE_W'(cur.addr));
                    check_output("mem_boff",  LINE_W'(bus.mem_boff),  LINE_W'(cur.boff));
                    check_output("mem_wdata", LINE_W'(bus.mem_wdata), LINE_W'(cur.wdata));
                    check_output("owner_d",   LINE_W'(bus.owner_d),   LINE_W'(cur.owner));
                end
            end else if (bus.mem_req && active) begin
                hi++;
                check_output("mem_addr_stable", LINE_W'(bus.mem_addr), LINE_W'(cur.addr));
            end
            if (!bus.mem_req && prev_req && active) begin
                if (cur.hi >= 0) check_output("mem_req_cycles", LINE_W'(hi), LINE_W'(cur.hi));
                active = 1'b0;
            end

            if (busy_next) begin
                check_output("busy_after_ack", LINE_W'(bus.arb_busy), 0);
                busy_next = 1'b0;
            end
            if (bus.i_ack && bus.d_ack) begin
                record_fail("both_acks", "got i_ack=1 d_ack=1, expected at most one");
            end else if (bus.i_ack || bus.d_ack) begin
                if (exp_ack_q.size() == 0) begin
                    record_fail("unexpected_ack", $sformatf("got i_ack=%0b d_ack=%0b, expected none",
                                                           bus.i_ack, bus.d_ack));
                end else begin
                    ea = exp_ack_q.pop_front();
                    check_output("ack_owner", LINE_W'(bus.d_ack), LINE_W'(ea.is_d));
                    check_output("ack_rdata", bus.d_ack ? bus.d_rdata : bus.i_rdata, ea.rdata);
                    check_output("ack_err", LINE_W'(bus.d_ack ? bus.d_err : bus.i_err), LINE_W'(ea.err));
                    if (!ea.err) check_output("ack_after_mem_ack", LINE_W'(prev_mack), 1);
                end
                busy_next = 1'b1;
            end
            prev_req  = bus.mem_req;
            prev_mack = bus.mem_ack;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        #2 reset_n = 1'b0;
        tick();
        tick();
        check_output("rst_mem_req",   LINE_W'(bus.mem_req),   0);
        check_output("rst_mem_we",    LINE_W'(bus.mem_we),    0);
        check_output("rst_mem_addr",  LINE_W'(bus.mem_addr),  0);
        check_output("rst_mem_boff",  LINE_W'(bus.mem_boff),  0);
        check_output("rst_mem_wdata", LINE_W'(bus.mem_wdata), 0);
        check_output("rst_acks",      LINE_W'({bus.i_ack, bus.d_ack}), 0);
        check_output("rst_i_rdata",   bus.i_rdata, 0);
        check_output("rst_d_rdata",   bus.d_rdata, 0);
        check_output("rst_errs",      LINE_W'({bus.i_err, bus.d_err}), 0);
        check_output("rst_arb_busy",  LINE_W'(bus.arb_busy), 0);
        check_output("rst_owner_d",   LINE_W'(bus.owner_d),   0);
        reset_n = 1'b1;
        tick();

        // Single I read; memory acks in the last allowed cycle, ack wins.
        $display("[TB] single I read");
        mem_latency = 4;
        expect_mem(1'b0, 8'h5A, 2'd0, 32'h0, 1'b0, 4);
        expect_ack(1'b0, line_for(8'h5A), 1'b0);
        apply_stimulus(1'b0, mk_req(1'b0, 8'h5A, 2'd0, 32'h0));
        tick();
        check_output("req_before_grant", LINE_W'({bus.i_req, bus.mem_req}), 2'b10);
        tick();
        check_output("grant_latency", LINE_W'(bus.mem_req), 1);
        wait_idle("i_read_done", 30);

        // D write-through: rdata must come back zero.
        $display("[TB] D write-through");
        mem_latency = 2;
        expect_mem(1'b1, 8'h13, 2'd2, 32'hCAFEF00D, 1'b1, 2);
        expect_ack(1'b1, '0, 1'b0);
        apply_stimulus(1'b1, mk_req(1'b1, 8'h13, 2'd2, 32'hCAFEF00D));
        wait_idle("d_write_done", 30);

        // Tie after reset: D first, then strict alternation.
        $display("[TB] tie and alternation");
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        expect_mem(1'b0, 8'h21, 2'd0, 32'h0, 1'b1, 2);
        expect_mem(1'b0, 8'h31, 2'd0, 32'h0, 1'b0, 2);
        expect_mem(1'b0, 8'h22, 2'd0, 32'h0, 1'b1, 2);
        expect_mem(1'b0, 8'h32, 2'd0, 32'h0, 1'b0, 2);
        expect_ack(1'b1, line_for(8'h21), 1'b0);
        expect_ack(1'b0, line_for(8'h31), 1'b0);
        expect_ack(1'b1, line_for(8'h22), 1'b0);
        expect_ack(1'b0, line_for(8'h32), 1'b0);
        apply_stimulus(1'b1, mk_req(1'b0, 8'h21, 2'd0, 32'h0));
        apply_stimulus(1'b1, mk_req(1'b0, 8'h22, 2'd0, 32'h0));
        apply_stimulus(1'b0, mk_req(1'b0, 8'h31, 2'd0, 32'h0));
        apply_stimulus(1'b0, mk_req(1'b0, 8'h32, 2'd0, 32'h0));
        wait_idle("tie_done", 60);

        // Timeout: memory never answers.
        $display("[TB] timeout");
        mem_latency = 0;
        expect_mem(1'b0, 8'h44, 2'd0, 32'h0, 1'b0, TIMEOUT_CYCLES);
        expect_ack(1'b0, '0, 1'b1);
        apply_stimulus(1'b0, mk_req(1'b0, 8'h44, 2'd0, 32'h0));
        wait_idle("timeout_done", 30);

        // Requester address changes while BUSY must not reach memory.
        $display("[TB] address change mid-transaction");
        mem_latency = 3;
        expect_mem(1'b0, 8'h77, 2'd0, 32'h0, 1'b1, 3);
        expect_ack(1'b1, line_for(8'h77), 1'b0);
        apply_stimulus(1'b1, mk_req(1'b0, 8'h77, 2'd0, 32'h0));
        wait_mem_req("addr_change_grant");
        d_addr_xor = 8'hFF;
        tick();
        tick();
        d_addr_xor = 8'h00;
        wait_idle("addr_change_done", 30);

        // Stray mem_ack while IDLE.
        $display("[TB] stray mem_ack");
        begin
            logic seen = 1'b0;
            stray_ack = 1'b1;
            for (int k = 0; k < 4; k++) begin
                tick();
                seen = seen | bus.i_ack | bus.d_ack | bus.arb_busy;
            end
            check_output("stray_ack_ignored", LINE_W'(seen), 0);
        end

        // Reset during BUSY aborts; pending I request is re-granted after.
        $display("[TB] reset during BUSY");
        mem_latency = 0;
        expect_mem(1'b0, 8'h66, 2'd0, 32'h0, 1'b0, -1);
        expect_mem(1'b0, 8'h66, 2'd0, 32'h0, 1'b0, 2);
        expect_ack(1'b0, line_for(8'h66), 1'b0);
        apply_stimulus(1'b0, mk_req(1'b0, 8'h66, 2'd0, 32'h0));
        wait_mem_req("abort_grant");
        tick();
        reset_n = 1'b0;
        #1;
        check_output("abort_mem_req",  LINE_W'(bus.mem_req),  0);
        check_output("abort_arb_busy", LINE_W'(bus.arb_busy), 0);
        check_output("abort_acks",     LINE_W'({bus.i_ack, bus.d_ack}), 0);
        check_output("abort_owner_d",  LINE_W'(bus.owner_d),  0);
        tick();
        tick();
        mem_latency = 2;
        reset_n = 1'b1;
        wait_idle("abort_regrant_done", 40);

        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache line-refill requester and the D-cache requester (line refill or write-through word).
- Sits between both cache controllers and main memory.
- Arbitrates round-robin, serialises one transaction at a time, and returns read lines or write completion with an optional timeout error.

Parameters:
- ADDR_W, 8, line address width (tag bits plus set bits).
- LINE_W, 128, refill line width.
- WORD_W, 32, write-through word width.
- TIMEOUT_CYCLES, 64, maximum cycles waiting for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache line-read request; level, held until i_ack.
- i_addr  in  ADDR_W  I-cache line address.
- i_ack  out  1  one-cycle completion pulse to the I-cache.
- i_rdata  out  LINE_W  returned line; valid while i_ack=1.
- i_err  out  1  timeout flag; valid while i_ack=1.
- d_req  in  1  D-cache request; level, held until d_ack.
- d_we  in  1  1 = word write-through, 0 = line read.
- d_addr  in  ADDR_W  D-cache line address.
- d_boff  in  2  word offset within the line (writes only).
- d_wdata  in  WORD_W  write data.
- d_ack  out  1  one-cycle completion pulse to the D-cache.
- d_rdata  out  LINE_W  returned line; valid while d_ack=1.
- d_err  out  1  timeout flag; valid while d_ack=1.
- mem_req  out  1  memory request; level, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory line address.
- mem_boff  out  2  memory word offset.
- mem_wdata  out  WORD_W  memory write data.
- mem_rdata  in  LINE_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; single-cycle pulse.
- arb_busy  out  1  high whenever state is not IDLE.
- owner_d  out  1  1 = current or last grant went to the D-cache.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_boff, mem_wdata, i_ack, d_ack, i_rdata, d_rdata, i_err, d_err, arb_busy).
  - owner_d=0, so the D-cache wins the first tie.
  - Timeout counter 0.
- Reset asserted mid-transaction aborts it immediately: no ack is issued and mem_req drops asynchronously.
- All outputs are registered.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant the requester not equal to owner_d (I if owner_d=1, D if owner_d=0).
  - On grant, next edge:
    - state becomes BUSY; mem_req=1; owner_d updates.
    - mem_addr, mem_boff and mem_we are latched from the winner. For I: mem_we=0, mem_boff=0, mem_wdata=0.
    - Counter cleared.
  - No request: stay in IDLE.
  - Grant latency: request seen at edge N gives mem_req=1 after edge N+1.
- BUSY:
  - mem_req and the latched address/data are held stable; new requester inputs are ignored.
  - Counter increments each cycle.
  - mem_ack=1:
    - next edge: mem_req=0, state RESP.
    - Owner's ack pulses (1 cycle) with rdata=mem_rdata captured (reads) or 0 (writes), err=0.
  - Timeout: TIMEOUT_CYCLES≠0, counter reaches TIMEOUT_CYCLES-1, and no mem_ack that cycle.
    - next edge: mem_req=0, state RESP, owner's ack=1, err=1, rdata=0.
  - mem_ack coincident with the timeout cycle: ack wins, err=0.
- RESP:
  - Single cycle, then IDLE. ack, err and rdata return to 0 on exit.
  - Requests are not sampled in RESP.
  - The requester drops its req on the edge it sees ack, so a back-to-back request from the same requester is granted from IDLE at the earliest 2 cycles after ack.
- The non-owner ack is never asserted; i_ack and d_ack are never high together.
- mem_ack seen in IDLE or RESP: ignored.
- Counter width: clog2(TIMEOUT_CYCLES+1). Counter saturates and never wraps.
- Fairness: with both requesters held continuously, grants strictly alternate, so worst-case wait is one transaction.

Test Plan:
- Single I read: i_req=1, i_addr=0x5A, memory acks 3 cycles after mem_req with rdata=0x…DEADBEEF -> mem_req=1/mem_we=0/mem_addr=0x5A one cycle after i_req; i_ack pulse 1 cycle after mem_ack with i_rdata=0x…DEADBEEF, i_err=0.
- D write-through: d_req=1, d_we=1, d_addr=0x13, d_boff=2, d_wdata=0xCAFEF00D -> mem_we=1, mem_boff=2, mem_wdata=0xCAFEF00D; d_ack=1, d_rdata=0.
- Tie after reset: i_req and d_req asserted in the same cycle -> D granted first (owner_d=1); I granted after the D transaction's RESP; grants alternate D,I,D,I across 4 held requests.
- Timeout: TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then i_ack=1 with i_err=1, i_rdata=0; arb_busy low the cycle after.
- Request change mid-transaction: d_addr changes while BUSY -> mem_addr unchanged; stray mem_ack in IDLE produces no ack.
- Async reset asserted during BUSY -> mem_req, arb_busy and all acks 0 immediately; after release, pending i_req is granted normally with owner_d reset to 0.
